// File: rtl/network_mul_pkg.sv
// Shared constants for the pipelined multiplier sharing block.
// Operand, product and latency widths used by the arbiter top.
package network_mul_pkg;

    localparam int MUL_A_W  = 16;
    localparam int MUL_B_W  = 15;
    localparam int MUL_P_W  = 30;
    localparam int MUL_LAT  = 2;
    localparam int MUL_OP_W = MUL_A_W + MUL_B_W;

endpackage

// File: rtl/network_mul_mul_16s_15s_30_3_1.sv
// Pipelined signed multiplier: operand regs then product reg.
// Two-cycle latency; ce freezes both stages; reset is synchronous.
module network_mul_mul_16s_15s_30_3_1 #(
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 15,
    parameter int dout_WIDTH = 30
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout
);

    logic signed [din0_WIDTH-1:0] a_reg;
    logic signed [din1_WIDTH-1:0] b_reg;
    logic signed [dout_WIDTH-1:0] p_reg;
    logic signed [dout_WIDTH-1:0] prod;

    // Sign-extend into the product width; low bits of the true product
    always_comb begin
        prod = dout_WIDTH'(a_reg) * dout_WIDTH'(b_reg);
    end

    // Operand and product stages, both held when ce is low
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg <= '0;
            b_reg <= '0;
            p_reg <= '0;
        end else if (ce) begin
            a_reg <= din0;
            b_reg <= din1;
            p_reg <= prod;
        end
    end

    assign dout = p_reg;

endmodule

// File: rtl/network_rr_arbiter.sv
// Round-robin arbiter: first request above ptr, with wrap.
// Outputs one-hot grant plus its encoded index; en gates all grants.
module network_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [IDW-1:0] j_w;

    // Scan NREQ slots starting just after the last winner
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j_w   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j_w = IDW'((int'(ptr) + k) % NREQ);
            if (en && !any && req[j_w]) begin
                any        = 1'b1;
                grant[j_w] = 1'b1;
                idx        = j_w;
            end
        end
    end

endmodule

// File: rtl/network_mul_share_arb.sv
// Shares one pipelined multiplier among NREQ requesters.
// ID tags ride alongside the product; result stalls freeze the pipe.
module network_mul_share_arb
    import network_mul_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*MUL_A_W-1:0] req_a,
    input  logic [NREQ*MUL_B_W-1:0] req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [MUL_P_W-1:0]      rsp_p,
    output logic [IDW-1:0]          rsp_id,
    output logic                    busy
);

    logic            v1_q, v1_d;
    logic            v2_q, v2_d;
    logic [IDW-1:0]  tag1_q, tag1_d;
    logic [IDW-1:0]  tag2_q, tag2_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

    logic            ce;
    logic            arb_en;
    logic            g_any;
    logic [IDW-1:0]  g_idx;
    logic [NREQ-1:0] grant;

    logic [MUL_OP_W-1:0] ops [NREQ];
    logic [MUL_OP_W-1:0] op_sel;
    logic [MUL_A_W-1:0]  din0;
    logic [MUL_B_W-1:0]  din1;

    assign ce     = ~v2_q | rsp_ready;
    // No grants while reset is held, so req_ready stays low
    assign arb_en = ce & ap_rst_n;

    network_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .en    (arb_en),
        .grant (grant),
        .idx   (g_idx),
        .any   (g_any)
    );

    // Pack each slot's {a,b} and pick the granted one
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            ops[i] = {req_a[i*MUL_A_W +: MUL_A_W],
                      req_b[i*MUL_B_W +: MUL_B_W]};
        end
        op_sel = ops[g_idx];
    end

    assign din0 = op_sel[MUL_OP_W-1 -: MUL_A_W];
    assign din1 = op_sel[MUL_B_W-1:0];

    network_mul_mul_16s_15s_30_3_1 #(
        .din0_WIDTH (MUL_A_W),
        .din1_WIDTH (MUL_B_W),
        .dout_WIDTH (MUL_P_W)
    ) u_mul (
        .clk   (ap_clk),
        .reset (~ap_rst_n),
        .ce    (ce),
        .din0  (din0),
        .din1  (din1),
        .dout  (rsp_p)
    );

    // Next state of valid/tag pipe and round-robin pointer
    always_comb begin
        v1_d     = v1_q;
        v2_d     = v2_q;
        tag1_d   = tag1_q;
        tag2_d   = tag2_q;
        rr_ptr_d = rr_ptr_q;
        if (ce) begin
            v1_d   = g_any;
            v2_d   = v1_q;
            tag2_d = tag1_q;
            if (g_any) begin
                tag1_d   = g_idx;
                rr_ptr_d = g_idx;
            end
        end
    end

    // Pipe state; pointer resets so slot 0 is searched first
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            tag1_q   <= '0;
            tag2_q   <= '0;
            rr_ptr_q <= IDW'(NREQ - 1);
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            tag1_q   <= tag1_d;
            tag2_q   <= tag2_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign req_ready = grant;
    assign rsp_valid = v2_q;
    assign rsp_id    = tag2_q;
    assign busy      = v1_q | v2_q;

endmodule
